// File: rtl/stats_digit_overlay.sv
// stats_digit_overlay: NUM_STATS right-aligned decimal counters over VGA bg.
// clk/rst_n, x/y/bg_rgb in, stat_value/stat_load in, busy/vga_rgb/in_field out.
module stats_digit_overlay #(
  parameter int NUM_STATS = 8,
  parameter int VAL_W     = 11,
  parameter int DIGITS    = 4,
  parameter int X0        = 155,
  parameter int Y0        = 30,
  parameter int CHAR_W    = 6,
  parameter int ROW_H     = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [10:0]                x,
  input  logic [10:0]                y,
  input  logic [11:0]                bg_rgb,
  input  logic [NUM_STATS*VAL_W-1:0] stat_value,
  input  logic                       stat_load,
  output logic                       busy,
  output logic [11:0]                vga_rgb,
  output logic                       in_field
);
  localparam int IW  = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = $clog2(VAL_W + 1);
  localparam int NB0 = (VAL_W * 302) / 1000 + 1;
  localparam int NB  = (NB0 > DIGITS) ? NB0 : DIGITS + 1;
  localparam int FW  = DIGITS * 4;

  localparam logic [10:0] XL  = 11'(X0);
  localparam logic [10:0] XH  = 11'(X0 + DIGITS * CHAR_W);
  localparam logic [10:0] YL  = 11'(Y0);
  localparam logic [10:0] YH  = 11'(Y0 + NUM_STATS * ROW_H);
  localparam logic [10:0] CWL = 11'(CHAR_W);
  localparam logic [10:0] RHL = 11'(ROW_H);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE, SWAP} state_t;

  typedef struct packed {
    logic          in;
    logic [IW-1:0] row;
    logic [DW-1:0] dig;
    logic [3:0]    gx;
    logic [3:0]    gy;
    logic [11:0]   bg;
  } s1_t;

  state_t state, state_nx;

  logic [VAL_W-1:0] snap  [NUM_STATS];
  logic [FW-1:0]    back  [NUM_STATS];
  logic [FW-1:0]    front [NUM_STATS];
  logic [VAL_W-1:0] work;
  logic [NB*4-1:0]  bcd, bcd_adj;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             last_bit, last_idx, sat;

  assign last_bit = cnt == CW'(VAL_W - 1);
  assign last_idx = idx == IW'(NUM_STATS - 1);
  // Anything above the shown digits means the value does not fit.
  assign sat      = |bcd[NB*4-1:FW];
  assign busy     = state != IDLE;

  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < NB; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5)
        bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (stat_load) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = STORE;
      STORE:   state_nx = last_idx ? SWAP : SHIFT;
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      cnt  <= '0;
      bcd  <= '0;
      work <= '0;
      for (int i = 0; i < NUM_STATS; i++) begin
        snap[i]  <= '0;
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (stat_load) begin
            for (int i = 0; i < NUM_STATS; i++)
              snap[i] <= stat_value[i*VAL_W +: VAL_W];
            work <= stat_value[VAL_W-1:0];
            idx  <= '0;
            cnt  <= '0;
            bcd  <= '0;
          end
        end
        SHIFT: begin
          bcd  <= {bcd_adj[NB*4-2:0], work[VAL_W-1]};
          work <= work << 1;
          cnt  <= cnt + 1'b1;
        end
        STORE: begin
          back[idx] <= sat ? {DIGITS{4'h9}} : bcd[FW-1:0];
          bcd <= '0;
          cnt <= '0;
          if (!last_idx) begin
            idx  <= idx + 1'b1;
            work <= snap[idx + 1'b1];
          end
        end
        SWAP: begin
          for (int i = 0; i < NUM_STATS; i++)
            front[i] <= back[i];
        end
        default: ;
      endcase
    end
  end

  function automatic logic [4:0] glyph_row(
    input logic [3:0] d,
    input logic [2:0] r
  );
    logic [34:0] g;
    logic [34:0] s;
    case (d)
      4'd0: g = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1: g = 35'b11100_00100_00100_00100_00100_00100_11111;
      4'd2: g = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3: g = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4: g = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5: g = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6: g = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7: g = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8: g = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9: g = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: g = '0;
    endcase
    s = g << (5 * r);
    return s[34:30];
  endfunction

  logic [10:0] dx, dy;
  logic        hit;
  s1_t         s1, s1_n;

  assign dx  = x - XL;
  assign dy  = y - YL;
  assign hit = (x >= XL) && (x < XH) && (y >= YL) && (y < YH);

  always_comb begin
    s1_n     = '0;
    s1_n.in  = hit;
    s1_n.row = hit ? IW'(dy / RHL) : '0;
    s1_n.dig = hit ? DW'(dx / CWL) : '0;
    s1_n.gx  = 4'(dx % CWL);
    s1_n.gy  = 4'(dy % RHL);
    s1_n.bg  = bg_rgb;
  end

  logic [FW-1:0] word;
  logic [3:0]    nib;
  logic [4:0]    grow, gsh;
  logic          seen, on;

  always_comb begin
    word = front[s1.row];
    nib  = '0;
    seen = 1'b0;
    // Blank a digit until a nonzero digit at or left of it appears.
    for (int d = 0; d < DIGITS; d++) begin
      if (DW'(d) <= s1.dig && word[(DIGITS-1-d)*4 +: 4] != 4'd0)
        seen = 1'b1;
      if (DW'(d) == s1.dig)
        nib = word[(DIGITS-1-d)*4 +: 4];
    end
    if (s1.dig == DW'(DIGITS - 1)) seen = 1'b1;
    grow = glyph_row(nib, s1.gy[2:0]);
    gsh  = grow << s1.gx[2:0];
    on   = s1.in && seen && (s1.gx < 4'd5) && (s1.gy < 4'd7) && gsh[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      vga_rgb  <= '0;
      in_field <= 1'b0;
    end else begin
      s1       <= s1_n;
      vga_rgb  <= on ? ~s1.bg : s1.bg;
      in_field <= s1.in;
    end
  end

endmodule
